// File: rtl/tail_bit_reset_tx.sv
// Tail-bit pin driver: forwards router tail bits with a run-length limiter, and on
// request emits a low/high/low reset sequence long enough for the downstream receiver.
module tail_bit_reset_tx #(
  parameter int N    = 3,
  parameter int HOLD = 8,
  parameter int GAP  = 4
) (
  input  logic our_clk,
  input  logic reset_n,
  input  logic req,
  input  logic tail_in,
  input  logic tail_valid,
  output logic tail_out,
  output logic tx_ready,
  output logic busy,
  output logic done,
  output logic clip_err
);

  localparam int MX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW = $clog2(MX + 1);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  generate
    if (HOLD < N + 2) begin : g_bad_hold
      $error("tail_bit_reset_tx: HOLD must be at least N+2");
    end
    if (GAP < 1) begin : g_bad_gap
      $error("tail_bit_reset_tx: GAP must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_ASSERT, S_RECOVER} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] run_q;
  logic          tail_q, done_q, clip_q;
  logic          hi;

  assign hi = tail_in & tail_valid;

  always_ff @(posedge our_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      run_q   <= '0;
      tail_q  <= 1'b0;
      done_q  <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            // Request wins over data this cycle; run clears so no long high spans the boundary.
            state_q <= S_DRAIN;
            cnt_q   <= CW'(GAP - 1);
            tail_q  <= 1'b0;
            run_q   <= '0;
          end else if (hi && run_q == RW'(N - 1)) begin
            tail_q <= 1'b0;
            clip_q <= 1'b1;
            run_q  <= '0;
          end else if (hi) begin
            tail_q <= 1'b1;
            run_q  <= run_q + RW'(1);
          end else begin
            tail_q <= 1'b0;
            run_q  <= '0;
          end
        end
        S_DRAIN: begin
          if (cnt_q == '0) begin
            state_q <= S_ASSERT;
            cnt_q   <= CW'(HOLD - 1);
            tail_q  <= 1'b1;
          end else begin
            cnt_q  <= cnt_q - CW'(1);
            tail_q <= 1'b0;
          end
        end
        S_ASSERT: begin
          if (cnt_q == '0) begin
            state_q <= S_RECOVER;
            cnt_q   <= CW'(GAP - 1);
            tail_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q - CW'(1);
            tail_q <= 1'b1;
          end
        end
        S_RECOVER: begin
          tail_q <= 1'b0;
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tail_out = tail_q;
  assign done     = done_q;
  assign clip_err = clip_q;
  assign tx_ready = (state_q == S_IDLE);
  assign busy     = ~tx_ready;

endmodule

// File: tb/tb_tail_bit_reset_tx.sv
// Scoreboard bench: driver runs a schedule-based reference model and queues expected
// outputs per cycle; a monitor pops and compares on each falling edge.
module tb_tail_bit_reset_tx;
  localparam int N = 3, HOLD = 8, GAP = 4;

  logic our_clk = 1'b0, reset_n = 1'b0, req = 1'b0, tail_in = 1'b0, tail_valid = 1'b0;
  logic tail_out, tx_ready, busy, done, clip_err;

  tail_bit_reset_tx #(.N(N), .HOLD(HOLD), .GAP(GAP)) dut (
    .our_clk(our_clk), .reset_n(reset_n), .req(req), .tail_in(tail_in),
    .tail_valid(tail_valid), .tail_out(tail_out), .tx_ready(tx_ready), .busy(busy),
    .done(done), .clip_err(clip_err)
  );

  always #5 our_clk = ~our_clk;

  typedef struct packed { logic tout, rdy, dn, clip; } exp_t;
  exp_t exp_q[$];
  int checks = 0, failures = 0;

  // Reference model: a reset sequence is a queue of pin values still to be played out.
  bit sched[$];
  bit in_seq = 0, m_clip = 0;
  int run = 0;
  int max_high = 0, cur_high = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge our_clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tail_out", 32'(tail_out), 32'(e.tout));
        chk("tx_ready", 32'(tx_ready), 32'(e.rdy));
        chk("busy", 32'(busy), 32'(!e.rdy));
        chk("done", 32'(done), 32'(e.dn));
        chk("clip_err", 32'(clip_err), 32'(e.clip));
      end
    end
  end

  // One cycle: apply inputs after a falling edge, predict outputs after the next rising edge.
  task automatic step(input bit rst, input bit r, input bit ti, input bit tv);
    exp_t e;
    @(negedge our_clk);
    #1;
    reset_n = !rst; req = r; tail_in = ti; tail_valid = tv;
    e = '0;
    if (rst) begin
      sched.delete(); in_seq = 0; m_clip = 0; run = 0;
      e.rdy = 1;
      #1;
      chk("rst_async_tail", 32'(tail_out), 32'd0);
      chk("rst_async_ready", 32'(tx_ready), 32'd1);
    end else if (in_seq) begin
      if (sched.size() != 0) begin
        e.tout = sched.pop_front();
        e.rdy = 0;
      end else begin
        in_seq = 0; e.dn = 1; e.rdy = 1;
      end
    end else if (r) begin
      for (int i = 0; i < GAP; i++) sched.push_back(1'b0);
      for (int i = 0; i < HOLD; i++) sched.push_back(1'b1);
      for (int i = 0; i < GAP; i++) sched.push_back(1'b0);
      in_seq = 1; run = 0;
      e.tout = sched.pop_front();
      e.rdy = 0;
    end else begin
      e.rdy = 1;
      if (ti && tv) begin
        if (run + 1 >= N) begin m_clip = 1; run = 0; end
        else begin e.tout = 1; run++; end
      end else run = 0;
    end
    e.clip = m_clip;
    if (e.tout && e.rdy) begin cur_high++; if (cur_high > max_high) max_high = cur_high; end
    else cur_high = 0;
    exp_q.push_back(e);
  endtask

  initial begin
    bit pat[5];
    int k_tick, ready_low;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    repeat (3) step(1, 0, 0, 0);
    repeat (20) step(0, 0, 0, 0);
    foreach (pat[i]) step(0, 0, pat[i], pat[i]);
    repeat (5) step(0, 0, 1, 1);
    repeat (2) step(0, 0, 0, 0);
    step(1, 0, 0, 0);

    // One-cycle request; measure tx_ready low span independently of the scoreboard.
    step(0, 1, 1, 1);
    ready_low = 0;
    for (int i = 0; i < 2 * GAP + HOLD + 4; i++) begin
      step(0, 0, 1, 1);
      if (!tx_ready) ready_low++;
    end
    chk("ready_low_span", 32'(ready_low), 32'(2 * GAP + HOLD));

    repeat (40) step(0, 1, 0, 0);
    repeat (20) step(0, 0, 0, 0);

    // Abort in the third ASSERT cycle.
    step(0, 1, 0, 0);
    repeat (GAP + 2) step(0, 0, 0, 0);
    chk("pre_abort_high", 32'(tail_out), 32'd1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      k_tick = $urandom_range(0, 199);
      step(k_tick == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    repeat (2) @(negedge our_clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("model_passthrough_run_bound", 32'(max_high < N), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
